// File: rtl/seq_detector_param_if.sv
// Serial-stream bus for the parametrised pattern detector: qualified data and pattern
// load in, Mealy match flag and saturating match statistics out.
interface seq_detector_param_if #(
    parameter int N     = 3,
    parameter int CNT_W = 8
);
    logic             x;
    logic             x_valid;
    logic [N-1:0]     pattern;
    logic             pat_load;
    logic             overlap;
    logic             y;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;

    modport master (
        output x, x_valid, pattern, pat_load, overlap,
        input  y, match_count, count_sat
    );

    modport slave (
        input  x, x_valid, pattern, pat_load, overlap,
        output y, match_count, count_sat
    );
endinterface

// File: rtl/seq_detector_param.sv
// Programmable N-bit serial pattern detector with a same-cycle Mealy match flag,
// overlap/non-overlap restart, runtime pattern load and a saturating match counter.
module seq_detector_param #(
    parameter int N     = 3,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_detector_param_if.slave  bus
);
    localparam int FILL_W = $clog2(N);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N - 1);

    logic [N-2:0]     hist, hist_next;
    logic [FILL_W-1:0] fill, fill_next;
    logic [N-1:0]     pat_reg;
    logic [N-1:0]     win;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             sat, sat_next;
    logic             match;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // The newest bit completes the window combinationally so y lands on the final bit.
    assign win   = {hist, bus.x};
    assign match = rst_n & bus.x_valid & ~bus.pat_load
                 & (fill == FILL_FULL) & (win == pat_reg);

    assign bus.y           = match;
    assign bus.match_count = cnt;
    assign bus.count_sat   = sat;

    always_comb begin
        hist_next = hist;
        fill_next = fill;
        cnt_next  = cnt;
        sat_next  = sat;
        if (bus.pat_load) begin
            hist_next = '0;
            fill_next = '0;
            cnt_next  = '0;
            sat_next  = 1'b0;
        end else if (bus.x_valid) begin
            if (match && !bus.overlap) begin
                hist_next = '0;
                fill_next = '0;
            end else begin
                hist_next = win[N-2:0];
                if (fill != FILL_FULL) begin
                    fill_next = fill + 1'b1;
                end
            end
            if (match) begin
                cnt_next = sat_inc(cnt);
                sat_next = (sat_inc(cnt) == '1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist    <= '0;
            fill    <= '0;
            pat_reg <= '1;
            cnt     <= '0;
            sat     <= 1'b0;
        end else begin
            hist <= hist_next;
            fill <= fill_next;
            cnt  <= cnt_next;
            sat  <= sat_next;
            if (bus.pat_load) begin
                pat_reg <= bus.pattern;
            end
        end
    end
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed-vector bench: a driver queues the expected per-cycle response and a monitor
// compares both detector instances (8-bit and 2-bit counters) against it.
module tb_seq_detector_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seq_detector_param_if #(.N(3), .CNT_W(8)) if_a ();
    seq_detector_param_if #(.N(3), .CNT_W(2)) if_b ();

    seq_detector_param #(.N(3), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    seq_detector_param #(.N(3), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    typedef struct {
        logic y;
        int   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   exp_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_cycle = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d required %0d", name, n_cycle, act, req);
        end
    endtask

    // Monitor: one expected record per driven cycle, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        int   cb;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            cb = (e.cnt > 3) ? 3 : e.cnt;
            n_cycle++;
            chk("y_a", {31'd0, if_a.y}, {31'd0, e.y});
            chk("y_b", {31'd0, if_b.y}, {31'd0, e.y});
            chk("count_a", {24'd0, if_a.match_count}, e.cnt);
            chk("sat_a", {31'd0, if_a.count_sat}, (e.cnt >= 255) ? 1 : 0);
            chk("count_b", {30'd0, if_b.match_count}, cb);
            chk("sat_b", {31'd0, if_b.count_sat}, (cb == 3) ? 1 : 0);
        end
    end

    task automatic drive(input logic r, input logic xv, input logic xb, input logic ld,
                         input logic [2:0] pat, input logic ov);
        rst_n         = r;
        if_a.x        = xb;  if_b.x        = xb;
        if_a.x_valid  = xv;  if_b.x_valid  = xv;
        if_a.pat_load = ld;  if_b.pat_load = ld;
        if_a.pattern  = pat; if_b.pattern  = pat;
        if_a.overlap  = ov;  if_b.overlap  = ov;
    endtask

    task automatic step(input logic r, input logic xv, input logic xb, input logic ld,
                        input logic [2:0] pat, input logic ov, input logic ey);
        exp_t e;
        @(posedge clk);
        #1;
        drive(r, xv, xb, ld, pat, ov);
        e.y   = ey;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
        if (!r || ld) exp_cnt = 0;
        else if (ey) exp_cnt++;
    endtask

    task automatic feed(input logic xb, input logic ov, input logic ey);
        step(1'b1, 1'b1, xb, 1'b0, 3'b000, ov, ey);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
    endtask

    task automatic reset_cycle(input logic xv);
        step(1'b0, xv, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
    endtask

    task automatic load(input logic [2:0] pat);
        step(1'b1, 1'b0, 1'b0, 1'b1, pat, 1'b1, 1'b0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        @(posedge clk);
        reset_cycle(1'b0);

        // Default pattern 111, overlap on
        feed(1, 1, 0); feed(1, 1, 0); feed(1, 1, 1); feed(1, 1, 1);
        idle();
        // Reset with a would-be completing bit present: y held low
        reset_cycle(1'b1);

        // Non-overlapping 111
        feed(1, 0, 0); feed(1, 0, 0); feed(1, 0, 1);
        feed(1, 0, 0); feed(1, 0, 0); feed(1, 0, 1);
        idle();

        // Pattern 101, overlap on then off
        load(3'b101);
        feed(1, 1, 0); feed(0, 1, 0); feed(1, 1, 1); feed(0, 1, 0); feed(1, 1, 1);
        load(3'b101);
        feed(1, 0, 0); feed(0, 0, 0); feed(1, 0, 1); feed(0, 0, 0); feed(1, 0, 0);
        idle();

        // Gaps in x_valid keep the partial match; gap cycles never match
        reset_cycle(1'b0);
        feed(1, 1, 0); idle(); feed(1, 1, 0); idle(); feed(1, 1, 1);
        idle();

        // Long run of ones: 5 matches, 2-bit counter saturates at 3
        reset_cycle(1'b0);
        for (int i = 0; i < 7; i++) feed(1, 1, (i >= 2) ? 1'b1 : 1'b0);
        idle(); idle();

        // Reset mid-stream discards partial match
        reset_cycle(1'b0);
        feed(1, 1, 0); feed(1, 1, 0);
        reset_cycle(1'b0);
        feed(1, 1, 0); feed(1, 1, 0); feed(1, 1, 1);
        idle();

        // pat_load coincident with a completing valid bit
        reset_cycle(1'b0);
        feed(1, 1, 0); feed(1, 1, 0); feed(1, 1, 1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 1'b1, 1'b0);
        idle();
        feed(1, 1, 0); feed(1, 1, 0); feed(1, 1, 1);
        idle();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d records left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
